ram_stream_reader: RTL and testbench

RAM_STREAM_READER -- requirements
Module: ram_stream_reader

---
 rtl/ram_stream_pkg.sv | 14 +
 rtl/stream_buf2.sv | 43 ++++
 rtl/ram_stream_reader.sv | 122 ++++++++++++
 tb/tb_ram_stream_reader.sv | 312 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ram_stream_pkg.sv
// Shared types and default widths for the RAM stream reader.
// Optional looping playback is enabled by defining RAM_STREAM_LOOP_EN.
package ram_stream_pkg;

    localparam int DEF_ADDRESS_WIDTH = 9;
    localparam int DEF_DATA_WIDTH    = 8;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_DRAIN
    } state_t;

endpackage

// File: rtl/stream_buf2.sv
// Two-entry valid/ready FIFO with occupancy output.
// The writer must only push when an entry is free or one is being popped in the same cycle.
module stream_buf2 #(
    parameter int DATA_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    input  logic [DATA_WIDTH-1:0] in_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic [1:0]            count
);

    logic [DATA_WIDTH-1:0] mem [2];
    logic                  wr_ptr;
    logic                  rd_ptr;
    logic                  pop;

    assign out_valid = (count != 2'd0);
    assign out_data  = mem[rd_ptr];
    assign pop       = out_valid && out_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem[0] <= '0;
            mem[1] <= '0;
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            count  <= 2'd0;
        end else begin
            if (in_valid) begin
                mem[wr_ptr] <= in_data;
                wr_ptr      <= ~wr_ptr;
            end
            if (pop)
                rd_ptr <= ~rd_ptr;
            count <= count + {1'b0, in_valid} - {1'b0, pop};
        end
    end

endmodule

// File: rtl/ram_stream_reader.sv
// Plays a burst of consecutive RAM words out on a valid/ready stream.
// Define RAM_STREAM_LOOP_EN to add the loop input for continuous replay.
module ram_stream_reader
    import ram_stream_pkg::*;
#(
    parameter int ADDRESS_WIDTH = DEF_ADDRESS_WIDTH,
    parameter int DATA_WIDTH    = DEF_DATA_WIDTH
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     start,
    input  logic [ADDRESS_WIDTH-1:0] base_addr,
    input  logic [ADDRESS_WIDTH:0]   length,
    output logic                     rd_en,
    output logic [ADDRESS_WIDTH-1:0] rd_addr,
    input  logic [DATA_WIDTH-1:0]    rd_data,
    output logic                     m_valid,
    input  logic                     m_ready,
    output logic [DATA_WIDTH-1:0]    m_data,
`ifdef RAM_STREAM_LOOP_EN
    input  logic                     loop,
`endif
    output logic                     busy,
    output logic                     done
);

    localparam logic [ADDRESS_WIDTH:0] LEN_ONE = (ADDRESS_WIDTH+1)'(1);

    state_t                   state, state_nxt;
    logic [ADDRESS_WIDTH-1:0] base_q;
    logic [ADDRESS_WIDTH:0]   len_q;
    logic [ADDRESS_WIDTH-1:0] next_addr;
    logic [ADDRESS_WIDTH-1:0] last_addr;
    logic [ADDRESS_WIDTH:0]   rd_left;
    logic [ADDRESS_WIDTH:0]   xfer_left;
    logic                     inflight;
    logic                     done_q;
    logic [1:0]               buf_count;
    logic [2:0]               outstanding;
    logic                     pop, start_ok, last_rd, last_xfer, loop_on;

`ifdef RAM_STREAM_LOOP_EN
    assign loop_on = loop;
`else
    assign loop_on = 1'b0;
`endif

    assign pop       = m_valid && m_ready;
    assign start_ok  = (state == ST_IDLE) && start && (length != '0);
    // Counting the word leaving this cycle keeps reads back-to-back under full throughput
    // while still guaranteeing the landing read always finds a free entry.
    assign outstanding = {1'b0, buf_count} + {2'b00, inflight} - {2'b00, pop};
    assign rd_en     = (state == ST_RUN) && (outstanding < 3'd2);
    assign rd_addr   = rd_en ? next_addr : last_addr;
    assign last_rd   = rd_en && (rd_left == LEN_ONE);
    assign last_xfer = pop && (xfer_left == LEN_ONE);
    assign busy      = (state != ST_IDLE);
    assign done      = done_q;

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:  if (start_ok) state_nxt = ST_RUN;
            ST_RUN:   if (last_rd && !loop_on) state_nxt = ST_DRAIN;
            // No reads remain, so the final transfer is the one that empties the buffer.
            ST_DRAIN: if (pop && buf_count == 2'd1 && !inflight) state_nxt = ST_IDLE;
            default:  state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state <= ST_IDLE;
        else
            state <= state_nxt;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            base_q    <= '0;
            len_q     <= '0;
            next_addr <= '0;
            last_addr <= '0;
            rd_left   <= '0;
            xfer_left <= '0;
            inflight  <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            inflight <= rd_en;
            done_q   <= last_xfer;
            if (start_ok) begin
                base_q    <= base_addr;
                len_q     <= length;
                next_addr <= base_addr;
                rd_left   <= length;
                xfer_left <= length;
            end else begin
                if (rd_en) begin
                    last_addr <= next_addr;
                    next_addr <= last_rd ? base_q : next_addr + ADDRESS_WIDTH'(1);
                    rd_left   <= last_rd ? len_q  : rd_left - LEN_ONE;
                end
                if (pop)
                    xfer_left <= last_xfer ? len_q : xfer_left - LEN_ONE;
            end
        end
    end

    stream_buf2 #(
        .DATA_WIDTH(DATA_WIDTH)
    ) u_buf (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_valid (inflight),
        .in_data  (rd_data),
        .out_valid(m_valid),
        .out_ready(m_ready),
        .out_data (m_data),
        .count    (buf_count)
    );

endmodule

// File: tb/tb_ram_stream_reader.sv
// Scoreboard bench for ram_stream_reader paired with a behavioural two-port RAM.
// Covers the loop feature when RAM_STREAM_LOOP_EN is defined.
module tb_ram_stream_reader;

    localparam int AW    = 9;
    localparam int DW    = 8;
    localparam int DEPTH = 1 << AW;

    typedef struct packed {
        logic [DW-1:0] data;
        logic          last;
    } word_t;

    typedef struct packed {
        logic [AW-1:0] addr;
        logic          last;
    } addr_t;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0;
    logic [AW-1:0] base_addr = '0;
    logic [AW:0]   length = '0;
    logic          rd_en;
    logic [AW-1:0] rd_addr;
    logic [DW-1:0] rd_data = '0;
    logic          m_valid;
    logic          m_ready = 1'b0;
    logic [DW-1:0] m_data;
    logic          busy;
    logic          done;
    logic          loop_val;
`ifdef RAM_STREAM_LOOP_EN
    logic          loop = 1'b0;
    assign loop_val = loop;
`else
    assign loop_val = 1'b0;
`endif

    logic [DW-1:0] mem [DEPTH];

    word_t exp_q[$];
    addr_t addr_q[$];
    int    checks = 0, failures = 0;
    int    cyc = 0, n_rd = 0, n_xfer = 0;
    int    first_xfer = -1, last_xfer_cyc = -1, burst_xfers = 0;
    int    pass_base = 0, pass_len = 0;
    int    ready_mode = 0;
    bit    model_busy = 0, done_next = 0, prev_stall = 0;
    logic [DW-1:0] prev_data = '0;

    always #5 clk = ~clk;

    always @(posedge clk) if (rd_en) rd_data <= mem[rd_addr];

    ram_stream_reader #(.ADDRESS_WIDTH(AW), .DATA_WIDTH(DW)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .base_addr(base_addr),
        .length   (length),
        .rd_en    (rd_en),
        .rd_addr  (rd_addr),
        .rd_data  (rd_data),
        .m_valid  (m_valid),
        .m_ready  (m_ready),
        .m_data   (m_data),
`ifdef RAM_STREAM_LOOP_EN
        .loop     (loop),
`endif
        .busy     (busy),
        .done     (done)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic void push_pass(input int b, input int l);
        for (int i = 0; i < l; i++) begin
            int    a;
            addr_t ae;
            word_t we;
            a = (b + i) % DEPTH;
            ae.addr = a[AW-1:0];
            ae.last = (i == l - 1);
            we.data = mem[a];
            we.last = (i == l - 1);
            addr_q.push_back(ae);
            exp_q.push_back(we);
        end
    endfunction

    // Monitor: every DUT-visible event is compared against the queued expectations.
    always @(negedge clk) begin
        cyc++;
        if (!rst_n) begin
            prev_stall = 0;
        end else begin
            check("done", {31'b0, done}, {31'b0, done_next});
            done_next = 0;
            check("busy", {31'b0, busy}, {31'b0, model_busy});
            if (rd_en) begin
                n_rd++;
                if (addr_q.size() == 0) begin
                    check("rd_en_unexpected", {23'b0, rd_addr}, 32'hFFFF_FFFF);
                end else begin
                    addr_t ae;
                    ae = addr_q.pop_front();
                    check("rd_addr", {23'b0, rd_addr}, {23'b0, ae.addr});
                    if (ae.last && loop_val) push_pass(pass_base, pass_len);
                end
            end
            if (prev_stall) begin
                check("stall_valid", {31'b0, m_valid}, 32'd1);
                check("stall_data", {24'b0, m_data}, {24'b0, prev_data});
            end
            if (m_valid && m_ready) begin
                n_xfer++;
                burst_xfers++;
                if (first_xfer < 0) first_xfer = cyc;
                last_xfer_cyc = cyc;
                if (exp_q.size() == 0) begin
                    check("word_unexpected", {24'b0, m_data}, 32'hFFFF_FFFF);
                end else begin
                    word_t we;
                    we = exp_q.pop_front();
                    check("m_data", {24'b0, m_data}, {24'b0, we.data});
                    if (we.last) done_next = 1;
                    if (exp_q.size() == 0 && addr_q.size() == 0) model_busy = 0;
                end
            end
            check("outstanding_le2", {31'b0, (n_rd - n_xfer) <= 2}, 32'd1);
            prev_stall = m_valid && !m_ready;
            prev_data  = m_data;
        end
    end

    initial begin
        forever begin
            @(posedge clk);
            #1;
            case (ready_mode)
                0:       m_ready = 1'b1;
                1:       m_ready = ~m_ready;
                2:       m_ready = ($urandom_range(0, 3) != 0);
                default: m_ready = 1'b0;
            endcase
        end
    end

    task automatic do_start(input int b, input int l, input bit release_rst);
        bit acc;
        @(posedge clk);
        #1;
        if (release_rst) rst_n = 1'b1;
        start     = 1'b1;
        base_addr = b[AW-1:0];
        length    = l[AW:0];
        acc = !model_busy && (l != 0);
        @(posedge clk);
        #1;
        start     = 1'b0;
        base_addr = AW'($urandom);
        length    = (AW+1)'($urandom);
        if (acc) begin
            model_busy = 1;
            pass_base  = b;
            pass_len   = l;
            push_pass(b, l);
        end
    endtask

    task automatic wait_idle(input int budget);
        int i;
        for (i = 0; i < budget; i++) begin
            @(posedge clk);
            #1;
            if (!model_busy && !busy) break;
        end
        if (i == budget) check("idle_timeout", 32'd0, 32'd1);
        repeat (2) @(posedge clk);
        #1;
    endtask

    task automatic clear_stats();
        first_xfer = -1;
        last_xfer_cyc = -1;
        burst_xfers = 0;
    endtask

    task automatic do_reset_flush();
        exp_q.delete();
        addr_q.delete();
        model_busy = 0;
        done_next  = 0;
        n_rd = 0;
        n_xfer = 0;
    endtask

    initial begin
        for (int i = 0; i < DEPTH; i++) mem[i] = i[DW-1:0];
        ready_mode = 0;
        repeat (3) @(posedge clk);
        #2;
        check("rst_rd_en", {31'b0, rd_en}, 32'd0);
        check("rst_m_valid", {31'b0, m_valid}, 32'd0);
        check("rst_busy", {31'b0, busy}, 32'd0);
        check("rst_done", {31'b0, done}, 32'd0);
        check("rst_rd_addr", {23'b0, rd_addr}, 32'd0);
        check("rst_m_data", {24'b0, m_data}, 32'd0);

        // Start raised together with reset release must be accepted on the very next edge.
        clear_stats();
        do_start(12'h010, 4, 1'b1);
        wait_idle(50);
        check("gapfree_base10", last_xfer_cyc - first_xfer, 32'd3);
        check("count_base10", burst_xfers, 32'd4);
        check("busy_after", {31'b0, busy}, 32'd0);

        clear_stats();
        do_start(12'h1FE, 4, 1'b0);
        wait_idle(50);
        check("count_wrap", burst_xfers, 32'd4);

        ready_mode = 1;
        clear_stats();
        do_start(12'h040, 8, 1'b0);
        wait_idle(100);
        check("count_toggle", burst_xfers, 32'd8);

        ready_mode = 0;
        do_start(12'h000, 16, 1'b0);
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        check("midrst_rd_en", {31'b0, rd_en}, 32'd0);
        check("midrst_m_valid", {31'b0, m_valid}, 32'd0);
        check("midrst_busy", {31'b0, busy}, 32'd0);
        check("midrst_done", {31'b0, done}, 32'd0);
        check("midrst_rd_addr", {23'b0, rd_addr}, 32'd0);
        check("midrst_m_data", {24'b0, m_data}, 32'd0);
        do_reset_flush();
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        clear_stats();
        do_start(12'h020, 2, 1'b0);
        wait_idle(50);
        check("count_after_rst", burst_xfers, 32'd2);

        do_start(12'h030, 0, 1'b0);
        repeat (5) @(posedge clk);
        #1;
        check("len0_busy", {31'b0, busy}, 32'd0);
        ready_mode = 2;
        clear_stats();
        do_start(12'h050, 6, 1'b0);
        do_start(12'h100, 5, 1'b0);
        wait_idle(100);
        check("count_start_busy", burst_xfers, 32'd6);

`ifdef RAM_STREAM_LOOP_EN
        ready_mode = 0;
        loop = 1'b1;
        clear_stats();
        do_start(12'h005, 3, 1'b0);
        repeat (14) @(posedge clk);
        #1;
        loop = 1'b0;
        wait_idle(100);
        check("loop_gapfree", last_xfer_cyc - first_xfer, burst_xfers - 1);
        check("loop_whole_passes", burst_xfers % 3, 32'd0);
        check("loop_multi_pass", {31'b0, burst_xfers > 6}, 32'd1);
`endif

        ready_mode = 0;
        clear_stats();
        do_start(12'h0A3, DEPTH, 1'b0);
        wait_idle(DEPTH + 50);
        check("full_gapfree", last_xfer_cyc - first_xfer, DEPTH - 1);
        check("full_count", burst_xfers, DEPTH);

        for (int t = 0; t < 15; t++) begin
            int b, l;
            for (int i = 0; i < DEPTH; i++) mem[i] = DW'($urandom);
            b = $urandom_range(0, DEPTH - 1);
            l = $urandom_range(1, 40);
            ready_mode = $urandom_range(0, 2);
            clear_stats();
            do_start(b, l, 1'b0);
            wait_idle(400);
            check("rand_count", burst_xfers, l);
        end

        repeat (3) @(posedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #800000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

endmodule
